pipe_mdu_seq: RTL and testbench

Multi-cycle multiply/divide sequencer attached to the EXE stage of the five-stage pipeline. It accepts a MULT/MULTU/DIV/DIVU operation presented with the EXE operands. It runs a 32-iteration shift-add or restoring-divide engine and holds the front of the pipeline with a stall while it runs. It then commits the 64-bit result to the architectural HI/LO registers.

---
 rtl/pipe_mdu_seq.sv | 178 +++++++++++++++++
 tb/tb_pipe_mdu_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mdu_seq.sv
// pipe_mdu_seq: 32-iteration MULT/MULTU/DIV/DIVU sequencer for the EXE stage; divider built only with MDU_DIV_EN.
// Latency: 33 stall cycles from acceptance in IDLE, then a one-cycle DONE with HI/LO updated.
// Backpressure: mdu_stall holds the front of the pipe while IDLE-accepting or RUN; ecancel kills an op without touching HI/LO.
module pipe_mdu_seq (
  input  logic        clock,
  input  logic        resetn,
  input  logic        estart,
  input  logic [1:0]  emduop,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic        ecancel,
  output logic        mdu_stall,
  output logic        mdu_done,
  output logic        mdu_busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic        rsign_q, rsign_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        op_ok;
  logic        start;
  logic        sa, sb;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] step_next;
  logic [63:0] prod_fix;
  logic [31:0] res_hi, res_lo;

`ifdef MDU_DIV_EN
  logic        is_div_q, is_div_d;
  logic        asign_q, asign_d;
  logic [32:0] div_r;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  logic [31:0] quo, rem;

  assign op_ok = 1'b1;
`else
  assign op_ok = ~emduop[1];
`endif

  assign start = estart & ~ecancel & op_ok;
  assign sa    = ~emduop[0] & ea[31];
  assign sb    = ~emduop[0] & eb[31];
  assign abs_a = sa ? (32'd0 - ea) : ea;
  assign abs_b = sb ? (32'd0 - eb) : eb;

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};
  assign mul_next = {mul_sum, acc_q[31:1]};
  assign prod_fix = rsign_q ? (64'd0 - step_next) : step_next;

`ifdef MDU_DIV_EN
  // Divide: acc holds {remainder, quotient}; the difference fits 32 bits whenever it is kept.
  assign div_r    = acc_q[63:31];
  assign div_ge   = (div_r >= {1'b0, opb_q});
  assign div_sub  = div_r[31:0] - opb_q;
  assign div_next = div_ge ? {div_sub, acc_q[30:0], 1'b1} : {div_r[31:0], acc_q[30:0], 1'b0};
  assign step_next = is_div_q ? div_next : mul_next;
  assign quo = step_next[31:0];
  assign rem = step_next[63:32];

  always_comb begin
    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
    if (is_div_q) begin
      // Divide-by-zero leaves the dividend in rem, so sign-fixing it restores ea.
      res_hi = asign_q ? (32'd0 - rem) : rem;
      if (opb_q == 32'd0) begin
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_lo = rsign_q ? (32'd0 - quo) : quo;
      end
    end
  end
`else
  assign step_next = mul_next;

  always_comb begin
    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    rsign_d = rsign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_DIV_EN
    is_div_d = is_div_q;
    asign_d  = asign_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = 6'd0;
          rsign_d = sa ^ sb;
          acc_d   = {32'd0, abs_b};
          opb_d   = abs_a;
`ifdef MDU_DIV_EN
          is_div_d = emduop[1];
          asign_d  = sa;
          if (emduop[1]) begin
            acc_d = {32'd0, abs_a};
            opb_d = abs_b;
          end
`endif
        end
      end
      S_RUN: begin
        if (ecancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_next;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = S_DONE;
            hi_d    = res_hi;
            lo_d    = res_lo;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      acc_q   <= 64'd0;
      opb_q   <= 32'd0;
      rsign_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      asign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      rsign_q <= rsign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_DIV_EN
      is_div_q <= is_div_d;
      asign_q  <= asign_d;
`endif
    end
  end

  assign mdu_stall = estart & ~ecancel & (((state_q == S_IDLE) & op_ok) | (state_q == S_RUN));
  assign mdu_busy  = (state_q == S_RUN);
  assign mdu_done  = (state_q == S_DONE);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_pipe_mdu_seq.sv
// Directed bench for pipe_mdu_seq: multiply, divide (or divide-rejection without MDU_DIV_EN), cancel, reset, back-to-back.
module tb_pipe_mdu_seq;

  logic        clock = 1'b0;
  logic        resetn;
  logic        estart;
  logic [1:0]  emduop;
  logic [31:0] ea;
  logic [31:0] eb;
  logic        ecancel;
  logic        mdu_stall;
  logic        mdu_done;
  logic        mdu_busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;
  int s1, s2;
  logic [1:0] cop;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  pipe_mdu_seq dut (
    .clock     (clock),
    .resetn    (resetn),
    .estart    (estart),
    .emduop    (emduop),
    .ea        (ea),
    .eb        (eb),
    .ecancel   (ecancel),
    .mdu_stall (mdu_stall),
    .mdu_done  (mdu_done),
    .mdu_busy  (mdu_busy),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Presents an op and holds estart until the done cycle; returns one cycle after done with estart still high.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, output int stalls);
    int cycles;
    cycles = 0;
    stalls = 0;
    estart = 1'b1;
    emduop = op;
    ea     = a;
    eb     = b;
    #1;
    while (mdu_done !== 1'b1 && cycles < 40) begin
      if (mdu_stall === 1'b1) stalls++;
      tick;
      cycles++;
    end
    check({tag, " done"}, {63'd0, mdu_done}, 64'd1);
    check({tag, " stall cycles"}, stalls, 64'd33);
    check({tag, " stall at done"}, {63'd0, mdu_stall}, 64'd0);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
    tick;
    check({tag, " done pulse width"}, {63'd0, mdu_done}, 64'd0);
  endtask

  initial begin
    resetn  = 1'b0;
    estart  = 1'b0;
    ecancel = 1'b0;
    emduop  = 2'b00;
    ea      = 32'd0;
    eb      = 32'd0;
    #12;
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    check("reset busy", {63'd0, mdu_busy}, 64'd0);
    check("reset done", {63'd0, mdu_done}, 64'd0);
    check("reset stall", {63'd0, mdu_stall}, 64'd0);
    tick;
    resetn = 1'b1;
    tick;

    run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, s1);
    estart = 1'b0;
    tick;
    run_op("mult -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, s1);
    estart = 1'b0;
    tick;
    run_op("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, s1);
    estart = 1'b0;
    tick;

`ifdef MDU_DIV_EN
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, s1);
    estart = 1'b0;
    tick;
    run_op("divu 100/0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, s1);
    estart = 1'b0;
    tick;
    run_op("div -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, s1);
    estart = 1'b0;
    tick;
    run_op("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, s1);
    estart = 1'b0;
    tick;
    cop = OP_DIVU;
`else
    estart = 1'b1;
    emduop = OP_DIV;
    ea     = 32'hFFFF_FFF9;
    eb     = 32'd2;
    #1;
    check("nodiv stall", {63'd0, mdu_stall}, 64'd0);
    s1 = 0;
    for (int i = 0; i < 36; i++) begin
      tick;
      if (mdu_done === 1'b1 || mdu_busy === 1'b1) s1++;
    end
    check("nodiv done/busy cycles", s1, 64'd0);
    emduop = OP_DIVU;
    #1;
    check("nodiv divu stall", {63'd0, mdu_stall}, 64'd0);
    tick;
    check("nodiv hi", {32'd0, hi}, 64'h4000_0000);
    check("nodiv lo", {32'd0, lo}, 64'd0);
    estart = 1'b0;
    tick;
    cop = OP_MULTU;
`endif

    // Cancel at counter 10 must leave the preloaded HI/LO alone.
    run_op("preload 2*3", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, s1);
    estart = 1'b0;
    tick;
    estart = 1'b1;
    emduop = cop;
    ea     = 32'd7;
    eb     = 32'd9;
    repeat (11) tick;
    check("cancel busy before", {63'd0, mdu_busy}, 64'd1);
    ecancel = 1'b1;
    #1;
    check("cancel stall", {63'd0, mdu_stall}, 64'd0);
    tick;
    check("cancel busy after", {63'd0, mdu_busy}, 64'd0);
    check("cancel done", {63'd0, mdu_done}, 64'd0);
    check("cancel hi", {32'd0, hi}, 64'd0);
    check("cancel lo", {32'd0, lo}, 64'd6);
    estart  = 1'b0;
    ecancel = 1'b0;
    s1 = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (mdu_done === 1'b1) s1++;
    end
    check("cancel no late done", s1, 64'd0);
    check("cancel lo hold", {32'd0, lo}, 64'd6);

    // Asynchronous reset at counter 20.
    estart = 1'b1;
    emduop = OP_MULTU;
    ea     = 32'hFFFF_FFFF;
    eb     = 32'hFFFF_FFFF;
    repeat (21) tick;
    check("midrun busy", {63'd0, mdu_busy}, 64'd1);
    resetn = 1'b0;
    #1;
    check("midrun reset busy", {63'd0, mdu_busy}, 64'd0);
    check("midrun reset hi", {32'd0, hi}, 64'd0);
    check("midrun reset lo", {32'd0, lo}, 64'd0);
    check("midrun reset done", {63'd0, mdu_done}, 64'd0);
    check("midrun reset stall", {63'd0, mdu_stall}, 64'd1);
    estart = 1'b0;
    tick;
    resetn = 1'b1;
    tick;

    run_op("b2b first", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, s1);
    run_op("b2b second", OP_MULTU, 32'd4, 32'd5, 32'd0, 32'd20, s2);
    check("b2b total stall", s1 + s2, 64'd66);
    estart = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
